// File: rtl/seq_pkg.sv
// Shared definitions for the instruction fetch unit: opcodes, field layout
// and FSM state encoding.
package seq_pkg;

  localparam int INST_W = 20;
  localparam int OP_W   = 4;
  localparam int DEV_W  = 3;
  localparam int ADDR_W = 8;
  localparam int NDEV   = 8;
  localparam int CNT_W  = 8;

  localparam logic [OP_W-1:0] OP_NO = 4'd0;
  localparam logic [OP_W-1:0] OP_CI = 4'd1;
  localparam logic [OP_W-1:0] OP_CR = 4'd2;
  localparam logic [OP_W-1:0] OP_JI = 4'd3;
  localparam logic [OP_W-1:0] OP_JR = 4'd4;
  localparam logic [OP_W-1:0] OP_JZ = 4'd5;

  // Instruction word layout: [19:16] opcode, [15] spare, [14:12] device, [11:0] arg.
  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic             rsv;
    logic [DEV_W-1:0] dev;
    logic [11:0]      arg;
  } inst_t;

  typedef enum logic [2:0] {
    ST_BOOT  = 3'd0,
    ST_IDLE  = 3'd1,
    ST_FETCH = 3'd2,
    ST_ISSUE = 3'd3,
    ST_ERROR = 3'd4
  } fetch_state_e;

  // Only device-touching opcodes can be held back by a busy device.
  function automatic logic is_dev_op(logic [OP_W-1:0] op);
    return (op == OP_CI) || (op == OP_CR);
  endfunction

endpackage

// File: rtl/seq_fetch_if.sv
// Sequencer / program-memory / device-status bundle seen by the fetch unit.
interface seq_fetch_if;
  import seq_pkg::*;

  logic              run;
  logic              step;
  logic [ADDR_W-1:0] next;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [INST_W-1:0] mem_data;
  logic [NDEV-1:0]   dev_busy;
  logic [INST_W-1:0] inst;
  logic              inst_en;
  logic              halted;
  logic              error;
  logic [CNT_W-1:0]  stall_cnt;

  modport master (
    input  run, step, next, mem_ack, mem_data, dev_busy,
    output mem_req, mem_addr, inst, inst_en, halted, error, stall_cnt
  );

  modport slave (
    output run, step, next, mem_ack, mem_data, dev_busy,
    input  mem_req, mem_addr, inst, inst_en, halted, error, stall_cnt
  );

endinterface

// File: rtl/seq_fetch_timeout.sv
// FETCH-state watchdog: counts enabled cycles, flags the TIMEOUT-th one.
module seq_fetch_timeout
  import seq_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // expired is high during the last allowed cycle so the FSM can leave on its edge
  assign expired = enable && (cnt_q == LIMIT);

  always_comb begin
    cnt_d = cnt_q;
    if (clear)                 cnt_d = '0;
    else if (enable && !expired) cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/seq_fetch.sv
// Instruction fetch/issue unit: fetches one word per request from program
// memory and hands it to the sequencer, holding CI/CR while their device is busy.
module seq_fetch
  import seq_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  seq_fetch_if.master bus
);

  fetch_state_e      state_q, state_d;
  logic              boot_cnt_q, boot_cnt_d;
  logic              mem_req_q, mem_req_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  inst_t             inst_q, inst_d;
  logic              step_pend_q, step_pend_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic go;
  logic stall;
  logic to_en;
  logic to_expired;

  assign go    = bus.run | step_pend_q;
  assign stall = is_dev_op(inst_q.op) && bus.dev_busy[inst_q.dev];
  assign to_en = (state_q == ST_FETCH);

  seq_fetch_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (!to_en),
    .enable  (to_en),
    .expired (to_expired)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_BOOT;
      boot_cnt_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      boot_cnt_q <= boot_cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    boot_cnt_d = boot_cnt_q;
    case (state_q)
      ST_BOOT: begin
        boot_cnt_d = 1'b1;
        if (boot_cnt_q) state_d = ST_IDLE;
      end
      ST_IDLE:  if (go) state_d = ST_FETCH;
      ST_FETCH: begin
        if (bus.mem_ack)     state_d = ST_ISSUE;
        else if (to_expired) state_d = ST_ERROR;
      end
      ST_ISSUE: if (!stall) state_d = ST_IDLE;
      ST_ERROR: state_d = ST_ERROR;
      default:  state_d = ST_ERROR;
    endcase
  end

  // Datapath registers updated alongside the FSM
  always_comb begin
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    inst_d      = inst_q;
    step_pend_d = step_pend_q;
    stall_cnt_d = stall_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (go) begin
          mem_req_d   = 1'b1;
          mem_addr_d  = bus.next;
          step_pend_d = 1'b0;
        end
      end
      ST_FETCH: begin
        if (bus.mem_ack) begin
          mem_req_d = 1'b0;
          inst_d    = inst_t'(bus.mem_data);
        end else if (to_expired) begin
          mem_req_d = 1'b0;
        end
      end
      ST_ISSUE: begin
        if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 8'd1;
      end
      ST_ERROR: mem_req_d = 1'b0;
      default: ;
    endcase
    // a fresh step wins over the clear so a pulse during IDLE->FETCH is not lost
    if (bus.step && (state_q != ST_ERROR)) step_pend_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      inst_q      <= '0;
      step_pend_q <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      inst_q      <= inst_d;
      step_pend_q <= step_pend_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Output logic
  always_comb begin
    bus.inst_en = (state_q == ST_ISSUE) && !stall;
    bus.halted  = (state_q == ST_IDLE) && !bus.run && !step_pend_q;
    bus.error   = (state_q == ST_ERROR);
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.inst      = inst_q;
  assign bus.stall_cnt = stall_cnt_q;

endmodule
